// File: rtl/dm_link_pkg.sv
// Shared constants, row decode and frame FSM encoding for the dot-matrix link capture.
package dm_link_pkg;
  localparam int CHAIN_BITS = 24;
  localparam int RED_LSB    = 16;
  localparam int GREEN_LSB  = 8;
  localparam int BLUE_LSB   = 0;
  localparam int ROWS       = 8;
  localparam int ROW_W      = 3;

  typedef enum logic [1:0] {FR_IDLE, FR_FILL, FR_DONE} frame_state_e;

  typedef struct packed {
    logic             vld;
    logic [ROW_W-1:0] row;
  } cat_row_t;

  // CAT[k] drives row ROWS-1-k; only a single active cathode is a legal select.
  function automatic cat_row_t cat_to_row(input logic [ROWS-1:0] cat);
    cat_row_t    r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int k = 0; k < ROWS; k++) begin
      if (cat[k]) begin
        n++;
        r.row = ROW_W'(ROWS - 1 - k);
      end
    end
    r.vld = (n == 1);
    return r;
  endfunction
endpackage

// File: rtl/dm_sync_edge.sv
// Multi-flop synchronizer for an async pin (or bus) with rise/fall pulses on the synced level.
module dm_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;
endmodule

// File: rtl/dot_matrix_frame_capture.sv
// Rebuilds red/blue frames from the 595-chain matrix link pins: emulated shift/storage
// registers, per-row commit on oe fall, and a row-order FSM that publishes complete frames.
module dot_matrix_frame_capture
  import dm_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CHAIN_BITS  = 24,
  parameter int ROWS        = 8
) (
  input  logic                CLOCK,
  input  logic                reset,
  input  logic                SH_CP,
  input  logic                ST_CP,
  input  logic                mr_n,
  input  logic                DS,
  input  logic                oe,
  input  logic [ROWS-1:0]     CAT,
  output logic [8*ROWS-1:0]   redmsg,
  output logic [8*ROWS-1:0]   bluemsg,
  output logic                row_valid,
  output logic [ROW_W-1:0]    row_idx,
  output logic                frame_valid,
  output logic [9:0]          frame_count,
  output logic                err_bits,
  output logic                err_cat,
  output logic                err_green
);
  logic sh_s, sh_rise, sh_fall, st_s, st_rise, st_fall;
  logic mr_s, mr_rise, mr_fall, ds_s, ds_rise, ds_fall;
  logic oe_s, oe_rise, oe_fall;
  logic [ROWS-1:0] cat_s, cat_rise, cat_fall;

  dm_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1)) u_sh (.clk_i(CLOCK), .rst_i(reset),
    .d_i(SH_CP), .level_o(sh_s), .rise_o(sh_rise), .fall_o(sh_fall));
  dm_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1)) u_st (.clk_i(CLOCK), .rst_i(reset),
    .d_i(ST_CP), .level_o(st_s), .rise_o(st_rise), .fall_o(st_fall));
  dm_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1)) u_mr (.clk_i(CLOCK), .rst_i(reset),
    .d_i(mr_n), .level_o(mr_s), .rise_o(mr_rise), .fall_o(mr_fall));
  dm_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1)) u_ds (.clk_i(CLOCK), .rst_i(reset),
    .d_i(DS), .level_o(ds_s), .rise_o(ds_rise), .fall_o(ds_fall));
  dm_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1)) u_oe (.clk_i(CLOCK), .rst_i(reset),
    .d_i(oe), .level_o(oe_s), .rise_o(oe_rise), .fall_o(oe_fall));
  dm_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(ROWS)) u_cat (.clk_i(CLOCK), .rst_i(reset),
    .d_i(CAT), .level_o(cat_s), .rise_o(cat_rise), .fall_o(cat_fall));

  logic unused_edges;
  assign unused_edges = ^{sh_s, sh_fall, st_s, st_fall, mr_rise, mr_fall, ds_rise, ds_fall,
                          oe_s, oe_rise, cat_rise, cat_fall};

  logic [CHAIN_BITS-1:0]      sreg_q, storage_q;
  logic [4:0]                 shift_cnt_q;
  logic [ROWS-1:0][7:0]       shadow_red_q, shadow_blue_q, red_q, blue_q;
  logic                       row_valid_q, frame_valid_q;
  logic                       err_bits_q, err_cat_q, err_green_q;
  logic [ROW_W-1:0]           row_idx_q, exp_q, exp_d;
  logic [9:0]                 frame_count_q;
  frame_state_e               state_q, state_d;
  cat_row_t                   cat_r;
  logic                       commit;

  always_comb cat_r = cat_to_row(cat_s);
  assign commit = oe_fall & cat_r.vld;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      sreg_q        <= '0;
      shift_cnt_q   <= '0;
      storage_q     <= '0;
      shadow_red_q  <= '0;
      shadow_blue_q <= '0;
      red_q         <= '0;
      blue_q        <= '0;
      row_valid_q   <= 1'b0;
      row_idx_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      err_bits_q    <= 1'b0;
      err_cat_q     <= 1'b0;
      err_green_q   <= 1'b0;
    end else begin
      // mr_n is level-sensitive and wins over a coincident shift
      if (!mr_s) begin
        sreg_q      <= '0;
        shift_cnt_q <= '0;
      end else if (sh_rise) begin
        sreg_q      <= {ds_s, sreg_q[CHAIN_BITS-1:1]};
        shift_cnt_q <= (&shift_cnt_q) ? shift_cnt_q : shift_cnt_q + 5'd1;
      end
      if (st_rise) storage_q <= sreg_q;

      row_valid_q <= commit;
      if (commit) begin
        row_idx_q                <= cat_r.row;
        shadow_red_q[cat_r.row]  <= storage_q[RED_LSB +: 8];
        shadow_blue_q[cat_r.row] <= storage_q[BLUE_LSB +: 8];
        if (shift_cnt_q != 5'(CHAIN_BITS))      err_bits_q  <= 1'b1;
        if (storage_q[GREEN_LSB +: 8] != 8'h00) err_green_q <= 1'b1;
      end
      if (oe_fall && !cat_r.vld) err_cat_q <= 1'b1;

      // DONE is entered the cycle row 7 lands in the shadow, so the copy includes it
      frame_valid_q <= (state_q == FR_DONE);
      if (state_q == FR_DONE) begin
        red_q         <= shadow_red_q;
        blue_q        <= shadow_blue_q;
        frame_count_q <= frame_count_q + 10'd1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q <= FR_IDLE;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    case (state_q)
      FR_IDLE: begin
        if (commit && cat_r.row == '0) begin
          state_d = FR_FILL;
          exp_d   = ROW_W'(1);
        end
      end
      FR_FILL: begin
        if (commit) begin
          if (cat_r.row == exp_q) begin
            if (exp_q == ROW_W'(ROWS - 1)) state_d = FR_DONE;
            else                           exp_d   = exp_q + ROW_W'(1);
          end else if (cat_r.row == exp_q - ROW_W'(1)) begin
            state_d = FR_FILL;
          end else if (cat_r.row == '0) begin
            exp_d = ROW_W'(1);
          end else begin
            state_d = FR_IDLE;
          end
        end
      end
      default: state_d = FR_IDLE;
    endcase
  end

  assign redmsg      = red_q;
  assign bluemsg     = blue_q;
  assign row_valid   = row_valid_q;
  assign row_idx     = row_idx_q;
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
  assign err_bits    = err_bits_q;
  assign err_cat     = err_cat_q;
  assign err_green   = err_green_q;
endmodule

// File: tb/tb_dot_matrix_frame_capture.sv
// Scoreboard bench: stimulus updates a pin-level link model and queues expectations;
// a negedge monitor pops and compares whenever the capture block reports rows or frames.
module tb_dot_matrix_frame_capture;
  logic        CLOCK = 1'b0;
  logic        reset = 1'b1;
  logic        SH_CP = 1'b0, ST_CP = 1'b0, mr_n = 1'b1, DS = 1'b0, oe = 1'b1;
  logic [7:0]  CAT = 8'h00;
  logic [63:0] redmsg, bluemsg;
  logic        row_valid, frame_valid, err_bits, err_cat, err_green;
  logic [2:0]  row_idx;
  logic [9:0]  frame_count;

  always #5 CLOCK = ~CLOCK;

  dot_matrix_frame_capture #(.SYNC_STAGES(2), .CHAIN_BITS(24), .ROWS(8)) dut (
    .CLOCK(CLOCK), .reset(reset), .SH_CP(SH_CP), .ST_CP(ST_CP), .mr_n(mr_n), .DS(DS),
    .oe(oe), .CAT(CAT), .redmsg(redmsg), .bluemsg(bluemsg), .row_valid(row_valid),
    .row_idx(row_idx), .frame_valid(frame_valid), .frame_count(frame_count),
    .err_bits(err_bits), .err_cat(err_cat), .err_green(err_green));

  typedef struct {
    logic [63:0] red;
    logic [63:0] blue;
    logic [9:0]  cnt;
  } frame_t;
  typedef enum {REQ_ERRS, REQ_ZERO, REQ_DRAIN} req_e;
  typedef struct {
    req_e kind;
    logic eb, ec, eg;
  } req_t;

  logic [2:0] row_q[$];
  frame_t     frame_q[$];
  req_t       req_q[$];
  int         n_checks = 0;
  int         n_errs   = 0;

  // Link model: the chain as a plain bit vector, rows as byte arrays, frame progress as
  // the length of the in-order run of rows seen since the last row 0.
  logic [23:0] m_sreg, m_stor;
  int          m_cnt, m_run;
  logic [7:0]  m_red[8], m_blue[8];
  logic [9:0]  m_fc;
  bit          m_eb, m_ec, m_eg;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic model_reset();
    m_sreg = '0; m_stor = '0; m_cnt = 0; m_run = 0; m_fc = '0;
    m_eb = 0; m_ec = 0; m_eg = 0;
    for (int r = 0; r < 8; r++) begin m_red[r] = '0; m_blue[r] = '0; end
    row_q.delete();
    frame_q.delete();
  endtask

  task automatic push_req(input req_e kind);
    req_t q;
    q.kind = kind; q.eb = m_eb; q.ec = m_ec; q.eg = m_eg;
    req_q.push_back(q);
  endtask

  task automatic frame_done();
    frame_t f;
    for (int r = 0; r < 8; r++) begin
      f.red[8*r +: 8]  = m_red[r];
      f.blue[8*r +: 8] = m_blue[r];
    end
    m_fc  = m_fc + 10'd1;
    f.cnt = m_fc;
    frame_q.push_back(f);
  endtask

  task automatic model_commit(input logic [7:0] cat);
    int r;
    if ($countones(cat) != 1) begin
      m_ec = 1;
      return;
    end
    r = 0;
    for (int k = 0; k < 8; k++) if (cat[k]) r = 7 - k;
    m_red[r]  = m_stor[23:16];
    m_blue[r] = m_stor[7:0];
    row_q.push_back(3'(r));
    if (m_cnt != 24) m_eb = 1;
    if (m_stor[15:8] != 8'h00) m_eg = 1;
    if (r == m_run) begin
      m_run++;
      if (m_run == 8) begin frame_done(); m_run = 0; end
    end else if (!(m_run > 0 && r == m_run - 1)) begin
      m_run = (r == 0) ? 1 : 0;
    end
  endtask

  // Pins are held for several cycles each, enough for the 2-flop synchronizers to see every level.
  task automatic shift_bit(input logic b);
    DS = b;
    wait_cyc(2);
    SH_CP = 1'b1;
    m_sreg = {b, m_sreg[23:1]};
    if (m_cnt < 31) m_cnt++;
    wait_cyc(4);
    SH_CP = 1'b0;
    wait_cyc(2);
  endtask

  task automatic load_row(input logic [7:0] red, input logic [7:0] green,
                          input logic [7:0] blue, input int nbits);
    logic [23:0] word;
    word = {red, green, blue};
    mr_n = 1'b0;
    wait_cyc(4);
    m_sreg = '0; m_cnt = 0;
    mr_n = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < nbits; i++) shift_bit(word[i]);
    ST_CP = 1'b1;
    m_stor = m_sreg;
    wait_cyc(4);
    ST_CP = 1'b0;
    wait_cyc(4);
  endtask

  task automatic commit(input logic [7:0] cat);
    CAT = cat;
    oe  = 1'b1;
    wait_cyc(4);
    oe = 1'b0;
    model_commit(cat);
    wait_cyc(4);
    push_req(REQ_ERRS);
  endtask

  task automatic send_row(input int r);
    load_row(8'($urandom), 8'h00, 8'($urandom), 24);
    commit(8'h80 >> r);
  endtask

  task automatic do_reset();
    SH_CP = 1'b0; ST_CP = 1'b0; mr_n = 1'b1; DS = 1'b0;
    reset = 1'b1;
    wait_cyc(1);
    model_reset();
    push_req(REQ_ZERO);
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(4);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_unexpected(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: pulse seen with nothing expected", name);
  endtask

  always @(negedge CLOCK) begin
    logic [2:0] er;
    frame_t     ef;
    req_t       rq;
    if (row_valid) begin
      if (row_q.size() == 0) chk_unexpected("row_valid");
      else begin
        er = row_q.pop_front();
        chk("row_idx", 64'(row_idx), 64'(er));
      end
    end
    if (frame_valid) begin
      if (frame_q.size() == 0) chk_unexpected("frame_valid");
      else begin
        ef = frame_q.pop_front();
        chk("redmsg", redmsg, ef.red);
        chk("bluemsg", bluemsg, ef.blue);
        chk("frame_count", 64'(frame_count), 64'(ef.cnt));
      end
    end
    while (req_q.size() > 0) begin
      rq = req_q.pop_front();
      case (rq.kind)
        REQ_ZERO: begin
          chk("reset redmsg", redmsg, 64'h0);
          chk("reset bluemsg", bluemsg, 64'h0);
          chk("reset pulses", 64'({row_valid, frame_valid, row_idx}), 64'h0);
          chk("reset frame_count", 64'(frame_count), 64'h0);
          chk("reset errs", 64'({err_bits, err_cat, err_green}), 64'h0);
        end
        REQ_ERRS: begin
          chk("err_bits", 64'(err_bits), 64'(rq.eb));
          chk("err_cat", 64'(err_cat), 64'(rq.ec));
          chk("err_green", 64'(err_green), 64'(rq.eg));
        end
        default: begin
          chk("rows outstanding", 64'(row_q.size()), 64'h0);
          chk("frames outstanding", 64'(frame_q.size()), 64'h0);
        end
      endcase
    end
  end

  initial begin
    logic [63:0] fr, fb;
    model_reset();
    wait_cyc(3);
    push_req(REQ_ZERO);
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(4);

    // single clean row 0
    load_row(8'hA5, 8'h00, 8'h3C, 24);
    commit(8'h80);

    // fixed full frame
    fr = 64'h0123_4567_89AB_CDEF;
    fb = ~fr;
    for (int r = 0; r < 8; r++) begin
      load_row(fr[8*r +: 8], 8'h00, fb[8*r +: 8], 24);
      commit(8'h80 >> r);
    end

    // illegal cathode patterns
    commit(8'h00);
    commit(8'h18);

    // out-of-order row abandons the frame, then a clean frame
    for (int r = 0; r < 3; r++) send_row(r);
    send_row(5);
    for (int r = 0; r < 8; r++) send_row(r);

    // random frame with random re-commits of the same row
    for (int r = 0; r < 8; r++) begin
      send_row(r);
      if ($urandom_range(0, 1) == 1) commit(8'h80 >> r);
    end

    // short shift count, then a nonzero green byte
    load_row(8'($urandom), 8'h00, 8'($urandom), 23);
    commit(8'h80);
    load_row(8'($urandom), 8'h5A, 8'($urandom), 24);
    commit(8'h40);

    // reset mid-frame, then a full frame and enough commit-only frames to wrap the count
    for (int r = 0; r < 5; r++) send_row(r);
    do_reset();
    for (int r = 0; r < 8; r++) send_row(r);
    for (int f = 0; f < 1023; f++)
      for (int r = 0; r < 8; r++) commit(8'h80 >> r);

    push_req(REQ_DRAIN);
    wait_cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
